// File: rtl/tick_gen.sv
// Runtime-loadable clock divider emitting a one-cycle registered pulse (periodic or one-shot); TICK_GEN_COUNT_EN adds a wrapping tick_count.
// Latency: first pulse D edges after leaving IDLE; enable=0 freezes the count and suppresses pulse.
module tick_gen #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 50000
`ifdef TICK_GEN_COUNT_EN
  ,
  parameter int CNT_W       = 8
`endif
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             mode,
  input  logic             start,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  output logic             pulse,
  output logic             busy,
  output logic [WIDTH-1:0] div_q
`ifdef TICK_GEN_COUNT_EN
  ,
  output logic [CNT_W-1:0] tick_count
`endif
);

  localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEFAULT_DIV);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] div_nxt;
  logic [WIDTH-1:0] d_eff;
  logic [WIDTH-1:0] reload;
  logic             pulse_nxt;

  // A divisor of 0 behaves as 1 so D-1 can never underflow.
  assign d_eff  = load ? ((div_in == '0) ? WIDTH'(1) : div_in) : div_q;
  assign reload = d_eff - WIDTH'(1);
  assign busy   = (state == RUN);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    div_nxt   = div_q;
    pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        div_nxt = d_eff;
        if (enable && (!mode || start)) begin
          state_nxt = RUN;
          cnt_nxt   = reload;
        end
      end
      RUN: begin
        // While frozen, count and divisor register both hold.
        if (enable) begin
          div_nxt = d_eff;
          if (mode && start) begin
            cnt_nxt = reload;
          end else if (cnt != '0) begin
            cnt_nxt = cnt - WIDTH'(1);
          end else begin
            pulse_nxt = 1'b1;
            if (!mode) cnt_nxt = reload;
            else       state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      div_q <= DEF_D;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pulse <= pulse_nxt;
      div_q <= div_nxt;
    end
  end

`ifdef TICK_GEN_COUNT_EN
  always_ff @(posedge clock) begin
    if (!reset_n)       tick_count <= '0;
    else if (pulse_nxt) tick_count <= tick_count + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: directed scenarios then random stimulus against an elapsed-cycle reference model.
module tb_tick_gen;
  localparam int WIDTH = 8;
  localparam int DEF   = 5;
  localparam int CNT_W = 2;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             mode = 1'b0;
  logic             start = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] div_in = '0;
  logic             pulse;
  logic             busy;
  logic [WIDTH-1:0] div_q;
`ifdef TICK_GEN_COUNT_EN
  logic [CNT_W-1:0] tick_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

`ifdef TICK_GEN_COUNT_EN
  tick_gen #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode), .start(start),
    .load(load), .div_in(div_in), .pulse(pulse), .busy(busy), .div_q(div_q),
    .tick_count(tick_count));
`else
  tick_gen #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode), .start(start),
    .load(load), .div_in(div_in), .pulse(pulse), .busy(busy), .div_q(div_q));
`endif

  // Reference model: counts enabled cycles elapsed in the current period and
  // fires when that reaches the period length latched at the period's start.
  bit m_run = 0;
  int m_elapsed = 0;
  int m_period = 0;
  int m_div = DEF;
  bit m_pulse = 0;
  int m_tc = 0;

  task automatic model_edge();
    int d;
    if (!reset_n) begin
      m_run = 0; m_elapsed = 0; m_pulse = 0; m_div = DEF; m_tc = 0;
      return;
    end
    d = load ? ((div_in == 0) ? 1 : int'(div_in)) : m_div;
    if (!m_run) begin
      m_div = d;
      m_pulse = 0;
      if (enable && (!mode || start)) begin
        m_run = 1; m_elapsed = 0; m_period = d;
      end
    end else if (!enable) begin
      m_pulse = 0;
    end else begin
      m_div = d;
      if (mode && start) begin
        m_elapsed = 0; m_period = d; m_pulse = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == m_period) begin
          m_pulse = 1;
          m_tc = (m_tc + 1) % (1 << CNT_W);
          if (!mode) begin m_elapsed = 0; m_period = d; end
          else m_run = 0;
        end else begin
          m_pulse = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check("model_pulse", 32'(pulse), 32'(m_pulse));
    check("model_busy", 32'(busy), 32'(m_run));
    check("model_div_q", 32'(div_q), 32'(m_div));
`ifdef TICK_GEN_COUNT_EN
    check("model_tick_count", 32'(tick_count), 32'(m_tc));
`endif
  endtask

  // Steps until pulse is seen; n = edges taken, or -1 if the bound expires.
  task automatic wait_pulse(output int n);
    bit found;
    found = 0;
    n = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      step();
      n++;
      if (pulse === 1'b1) found = 1;
    end
    if (!found) n = -1;
  endtask

  initial begin
    int n;
    // 1: reset values, then periodic with the default divisor
    reset_n = 0;
    step();
    check("rst_pulse", 32'(pulse), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_div_q", 32'(div_q), DEF);
    reset_n = 1; enable = 1; mode = 0;
    step();
    check("t1_busy_entry", 32'(busy), 1);
    wait_pulse(n);
    check("t1_first_period", n, 5);
    wait_pulse(n);
    check("t1_second_period", n, 5);
    check("t1_busy", 32'(busy), 1);

    // 2: load 3 mid-period; the running period still ends at 5
    step(); step();
    load = 1; div_in = 3;
    step();
    load = 0;
    check("t2_div_q_on_load", 32'(div_q), 3);
    wait_pulse(n);
    check("t2_period_finish", n, 2);
    wait_pulse(n);
    check("t2_new_period", n, 3);

    // 3: divisor 0 clamps to 1; enable gap freezes timing
    load = 1; div_in = 0;
    step();
    load = 0;
    check("t3_div_q_clamp", 32'(div_q), 1);
    wait_pulse(n);
    check("t3_drain", n, 2);
    wait_pulse(n);
    check("t3_every_cycle", n, 1);
    enable = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_frozen_pulse", 32'(pulse), 0);
    end
    enable = 1;
    wait_pulse(n);
    check("t3_resume", n, 1);

    // 4: one-shot D=4 and retrigger at cnt==1
    mode = 1; load = 1; div_in = 4;
    step();
    load = 0; start = 1;
    step();
    start = 0;
    wait_pulse(n);
    check("t4_oneshot", n, 4);
    check("t4_busy_after", 32'(busy), 0);
    start = 1; step();
    start = 0; step(); step();
    start = 1; step();
    start = 0;
    wait_pulse(n);
    check("t4_retrigger", n, 4);

    // 5: reset at terminal count suppresses the pulse
    mode = 0;
    step(); step(); step(); step();
    reset_n = 0;
    step();
    check("t5_pulse", 32'(pulse), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_div_q", 32'(div_q), DEF);
    reset_n = 1;

`ifdef TICK_GEN_COUNT_EN
    // 6: tick_count wraps at 2 bits with D=1
    begin
      int exp_tc [5] = '{1, 2, 3, 0, 1};
      reset_n = 0; step();
      reset_n = 1; mode = 0; enable = 1; load = 1; div_in = 0;
      step();
      load = 0;
      for (int i = 0; i < 5; i++) begin
        step();
        check("t6_pulse", 32'(pulse), 1);
        check("t6_tick_count", 32'(tick_count), 32'(exp_tc[i]));
      end
    end
`endif

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      enable  = ($urandom_range(0, 9) != 0);
      mode    = ($urandom_range(0, 3) == 0);
      start   = ($urandom_range(0, 7) == 0);
      load    = ($urandom_range(0, 15) == 0);
      div_in  = WIDTH'($urandom_range(0, 7));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
